// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the single-cycle RV32 core.
//   - Machine width and memory depths (XLEN, IMEM_WORDS, DMEM_WORDS).
//   - Opcode, funct3 and funct7 encodings for the supported instructions.
//   - ALU operation and write-back source enums, plus the ALU helper function.
// Optional feature macro: CORE_MUL_EN (adds the MUL operation to the ALU).
package core_pkg;

  localparam int XLEN       = 32;
  localparam int IMEM_WORDS = 256;
  localparam int DMEM_WORDS = 256;

  // Major opcodes
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // funct3 encodings
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct7 encodings for the OP major opcode
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_SUB    = 2'd1,
    ALU_MUL    = 2'd2,
    ALU_PASS_B = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // 32-bit wrap-around arithmetic; the product keeps only its low word.
  function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
`ifdef CORE_MUL_EN
      ALU_MUL:    r = a * b;
`endif
      ALU_PASS_B: r = b;
      default:    r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_dmem.sv
// core_dmem: 256 x 32 data memory, not reset.
//   clk_i, rst_i      : clock; reset only suppresses writes on an edge seen during reset
//   we_i              : store enable (SW)
//   addr_i            : word index (byte address bits [9:2])
//   wdata_i / rdata_o : write data / combinational read data
module core_dmem
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [7:0]      addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem [DMEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i && !rst_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/core_fetch.sv
// core_imem: 256 x 32 instruction memory, not reset, combinational read.
//   clk_i                  : clock
//   we_i, waddr_i, wdata_i : synchronous write port (tied off by the core)
//   raddr_i / rdata_o      : combinational word read
// core_fetch: program counter plus instruction memory.
//   clk_i, rst_i : clock, asynchronous active-high reset (pc -> 0)
//   next_pc_i    : pc loaded on every rising edge
//   pc_o         : current pc
//   instr_o      : instruction at imem[pc[9:2]]
module core_imem
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [7:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [7:0]      raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem [IMEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

module core_fetch
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] next_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  assign pc_d = next_pc_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  // Only word-index bits address the memory, so the pc wraps every 1 KiB.
  core_imem imem_inst (
    .clk_i   (clk_i),
    .we_i    (1'b0),
    .waddr_i (8'd0),
    .wdata_i ('0),
    .raddr_i (pc_q[9:2]),
    .rdata_o (instr_o)
  );

  assign pc_o = pc_q;

endmodule

// File: rtl/core_regfile.sv
// core_regfile: 32 x 32 register file.
//   clk_i, rst_i           : clock, asynchronous active-high reset (clears all registers)
//   we_i, waddr_i, wdata_i : synchronous write port (writes to x0 are dropped)
//   raddr1_i / rdata1_o    : combinational read port 1 (x0 reads as zero)
//   raddr2_i / rdata2_o    : combinational read port 2 (x0 reads as zero)
module core_regfile
  import core_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] reg_s [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) reg_s[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      reg_s[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : reg_s[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : reg_s[raddr2_i];

endmodule

// File: rtl/core.sv
// core: single-cycle RV32 subset (ADDI, ADD, SUB, LW, SW, BEQ, JAL, JALR, LUI).
//   clk   : rising-edge clock, one instruction retired per cycle
//   reset : asynchronous active-high reset (pc and registers cleared)
// All state is observed hierarchically: fetch_inst.imem_inst.mem,
// data_mem_inst.mem, regfile_inst.reg_s.
// Optional feature macro: CORE_MUL_EN (enables MUL; otherwise that
// encoding is treated as an illegal instruction, i.e. a NOP).
module core
  import core_pkg::*;
(
  input  logic clk,
  input  logic reset
);

  logic [XLEN-1:0] pc, instr, next_pc, pc_plus4;
  logic [XLEN-1:0] rs1_data, rs2_data, dmem_rdata;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] alu_b, alu_res, wb_data, jalr_tgt;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  alu_op_e         alu_op;
  wb_sel_e         wb_sel;
  logic            reg_we, mem_we;

  core_fetch fetch_inst (
    .clk_i     (clk),
    .rst_i     (reset),
    .next_pc_i (next_pc),
    .pc_o      (pc),
    .instr_o   (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};

  core_regfile regfile_inst (
    .clk_i    (clk),
    .rst_i    (reset),
    .we_i     (reg_we),
    .waddr_i  (rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  assign pc_plus4 = pc + 32'd4;
  // JALR target kept separate from the ALU so next_pc never feeds back into decode.
  assign jalr_tgt = (rs1_data + imm_i) & ~32'd1;

  // Decode: anything not matched keeps the defaults, which is a NOP.
  always_comb begin
    alu_op  = ALU_ADD;
    alu_b   = rs2_data;
    wb_sel  = WB_ALU;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      OPC_OPIMM: begin
        if (funct3 == F3_ADD) begin
          reg_we = 1'b1;
          alu_b  = imm_i;
        end
      end
      OPC_OP: begin
        if (funct3 == F3_ADD) begin
          if (funct7 == F7_ADD) begin
            reg_we = 1'b1;
          end else if (funct7 == F7_SUB) begin
            reg_we = 1'b1;
            alu_op = ALU_SUB;
          end
`ifdef CORE_MUL_EN
          else if (funct7 == F7_MUL) begin
            reg_we = 1'b1;
            alu_op = ALU_MUL;
          end
`endif
        end
      end
      OPC_LOAD: begin
        if (funct3 == F3_WORD) begin
          reg_we = 1'b1;
          alu_b  = imm_i;
          wb_sel = WB_MEM;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_WORD) begin
          mem_we = 1'b1;
          alu_b  = imm_s;
        end
      end
      OPC_BRANCH: begin
        if ((funct3 == F3_BEQ) && (rs1_data == rs2_data)) next_pc = pc + imm_b;
      end
      OPC_JAL: begin
        reg_we  = 1'b1;
        wb_sel  = WB_PC4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == F3_JALR) begin
          reg_we  = 1'b1;
          wb_sel  = WB_PC4;
          next_pc = jalr_tgt;
        end
      end
      OPC_LUI: begin
        reg_we = 1'b1;
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
      end
      default: ;
    endcase
  end

  assign alu_res = alu_eval(alu_op, rs1_data, alu_b);

  core_dmem data_mem_inst (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (mem_we),
    .addr_i  (alu_res[9:2]),
    .wdata_i (rs2_data),
    .rdata_o (dmem_rdata)
  );

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = dmem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

endmodule

// File: tb/tb_core.sv
// tb_core: directed program for core. Each table row is one retired
// instruction with its expected next pc and one expected register or
// data-memory value; a hand-written sequence covers mid-run reset.
module tb_core;

  logic clk;
  logic reset;

  core dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, OLD = 7'b0000011,
                         OST = 7'b0100011, OBR = 7'b1100011, OJAL = 7'b1101111,
                         OJALR = 7'b1100111, OLUI = 7'b0110111;

`ifdef CORE_MUL_EN
  localparam logic [31:0] MUL_EXP = 32'd200;
`else
  localparam logic [31:0] MUL_EXP = 32'd0;
`endif

  typedef struct {
    logic        ld;      // load instr into imem[word] before the run
    logic [7:0]  word;
    logic [31:0] instr;
    logic [31:0] exp_pc;  // pc after the edge
    logic        is_mem;  // check data memory instead of a register
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OPR};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OST};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OBR};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OJAL};
  endfunction

  function automatic void add_vec(input logic ld, input logic [7:0] word,
                                  input logic [31:0] instr, input logic [31:0] exp_pc,
                                  input logic is_mem, input int idx, input logic [31:0] exp);
    vec_t v;
    v.ld = ld; v.word = word; v.instr = instr; v.exp_pc = exp_pc;
    v.is_mem = is_mem; v.idx = idx; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] get_reg(input int idx);
    return dut.regfile_inst.reg_s[idx[4:0]];
  endfunction

  function automatic logic [31:0] get_mem(input int idx);
    return dut.data_mem_inst.mem[idx[7:0]];
  endfunction

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, tag, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;

    // Program table: word, instruction, pc after, check target, expected.
    add_vec(1, 0,  enc_i(12'd10, 0, 3'b000, 1, OPI),  32'h04, 0, 1,  32'd10);
    add_vec(1, 1,  enc_i(12'd20, 0, 3'b000, 2, OPI),  32'h08, 0, 2,  32'd20);
    add_vec(1, 2,  enc_r(7'h00, 2, 1, 3),             32'h0C, 0, 3,  32'd30);
    add_vec(1, 3,  enc_r(7'h20, 1, 2, 5),             32'h10, 0, 5,  32'd10);
    add_vec(1, 4,  enc_r(7'h01, 2, 1, 7),             32'h14, 0, 7,  MUL_EXP);
    add_vec(1, 5,  enc_i(12'd20, 0, 3'b000, 4, OPI),  32'h18, 0, 4,  32'd20);
    add_vec(1, 6,  enc_s(12'd0, 3, 0),                32'h1C, 1, 0,  32'd30);
    add_vec(1, 7,  enc_i(12'd0, 0, 3'b010, 9, OLD),   32'h20, 0, 9,  32'd30);
    add_vec(1, 8,  enc_s(12'd4, 4, 0),                32'h24, 1, 1,  32'd20);
    add_vec(1, 9,  enc_b(13'd12, 1, 1),               32'h30, 0, 1,  32'd10);
    add_vec(1, 12, enc_i(12'd111, 0, 3'b000, 11, OPI), 32'h34, 0, 11, 32'd111);
    add_vec(1, 13, enc_b(13'd8, 2, 1),                32'h38, 0, 10, 32'd0);
    add_vec(1, 14, enc_i(12'd5, 0, 3'b000, 12, OPI),  32'h3C, 0, 12, 32'd5);
    add_vec(1, 15, enc_i(12'hFFF, 0, 3'b000, 16, OPI), 32'h40, 0, 16, 32'hFFFF_FFFF);
    add_vec(1, 16, enc_r(7'h00, 16, 16, 17),          32'h44, 0, 17, 32'hFFFF_FFFE);
    add_vec(1, 17, enc_i(12'd5, 0, 3'b000, 0, OPI),   32'h48, 0, 0,  32'd0);
    add_vec(1, 18, enc_j(21'd16, 13),                 32'h58, 0, 13, 32'h4C);
    add_vec(1, 22, {20'h12345, 5'd15, OLUI},          32'h5C, 0, 15, 32'h1234_5000);
    add_vec(1, 23, 32'hFFFF_FFFF,                     32'h60, 0, 31, 32'd0);
    add_vec(1, 24, enc_s(12'hFFC, 4, 0),              32'h64, 1, 255, 32'd20);
    add_vec(1, 25, enc_i(12'hFFC, 0, 3'b010, 19, OLD), 32'h68, 0, 19, 32'd20);
    add_vec(1, 26, enc_i(12'd6, 0, 3'b010, 20, OLD),  32'h6C, 0, 20, 32'd20);
    add_vec(1, 27, enc_i(12'd4, 1, 3'b000, 14, OJALR), 32'h0E, 0, 14, 32'h70);
    // After JALR to 0xE the core re-fetches word 3 (SUB) then word 4 (MUL).
    add_vec(0, 3,  32'd0,                             32'h12, 0, 5,  32'd10);
    add_vec(0, 4,  32'd0,                             32'h16, 0, 7,  MUL_EXP);

    for (int i = 0; i < 256; i++) dut.fetch_inst.imem_inst.mem[8'(i)] = 32'h0000_0013;
    // Words that must never execute: they would write x10.
    dut.fetch_inst.imem_inst.mem[10] = enc_i(12'd1, 0, 3'b000, 10, OPI);
    dut.fetch_inst.imem_inst.mem[11] = enc_i(12'd1, 0, 3'b000, 10, OPI);
    dut.fetch_inst.imem_inst.mem[19] = enc_i(12'd3, 0, 3'b000, 10, OPI);
    dut.fetch_inst.imem_inst.mem[20] = enc_i(12'd3, 0, 3'b000, 10, OPI);
    dut.fetch_inst.imem_inst.mem[21] = enc_i(12'd3, 0, 3'b000, 10, OPI);
    foreach (vecs[i]) begin
      if (vecs[i].ld) dut.fetch_inst.imem_inst.mem[vecs[i].word] = vecs[i].instr;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", 0, dut.fetch_inst.pc_q, 32'd0);
    check("reset_x1", 1, get_reg(1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven run, one instruction per edge
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      check("pc", i, dut.fetch_inst.pc_q, vecs[i].exp_pc);
      if (vecs[i].is_mem) check("dmem", vecs[i].idx, get_mem(vecs[i].idx), vecs[i].exp);
      else                check("reg", vecs[i].idx, get_reg(vecs[i].idx), vecs[i].exp);
    end
    check("skipped_x10", 10, get_reg(10), 32'd0);
    check("nop_dmem0", 0, get_mem(0), 32'd30);

    // Mid-run asynchronous reset, asserted away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    check("async_pc", 0, dut.fetch_inst.pc_q, 32'd0);
    for (int r = 0; r < 32; r++) check("async_reg", r, get_reg(r), 32'd0);
    check("persist_dmem", 1, get_mem(1), 32'd20);
    @(posedge clk);
    #1;
    check("held_pc", 0, dut.fetch_inst.pc_q, 32'd0);
    check("held_x4", 4, get_reg(4), 32'd0);
    check("held_dmem", 255, get_mem(255), 32'd20);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("restart_pc", 0, dut.fetch_inst.pc_q, 32'h04);
    check("restart_x1", 1, get_reg(1), 32'd10);
    @(posedge clk);
    #1;
    check("restart_x2", 2, get_reg(2), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 Parameters: none; memory depth fixed at 256 words each.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 The core SHALL have no other ports; all state is observed by hierarchical access.
REQ-005 Hierarchy names SHALL be:
- fetch_inst.imem_inst.mem: instruction memory, 256 x 32.
- data_mem_inst.mem: data memory, 256 x 32.
- regfile_inst.reg_s: register file, 32 x 32.

Function
REQ-006 The core SHALL be single-cycle RV32 and retire one instruction per clk.
REQ-007 Instruction fetch SHALL be combinational from imem[pc[9:2]]; pc advances every rising edge.
REQ-008 Supported instructions:
- ADDI (opcode 0010011, f3 000).
- ADD and SUB (opcode 0110011, f3 000, f7 0000000 / 0100000).
- LW (0000011, f3 010) and SW (0100011, f3 010).
- BEQ (1100011, f3 000).
- JAL (1101111) and JALR (1100111, f3 000).
- LUI (0110111).
REQ-009 Immediates SHALL be sign-extended per RISC-V I/S/B/J formats; the LUI immediate is imm[31:12]<<12.
REQ-010 next_pc SHALL be:
- pc+B-imm for BEQ when rs1==rs2.
- pc+J-imm for JAL.
- (rs1+I-imm) & ~1 for JALR.
- pc+4 otherwise.
REQ-011 JAL and JALR SHALL write pc+4 to rd.
REQ-012 Register writes SHALL occur at the rising edge; reads SHALL be combinational on two read ports.
REQ-013 Writes to x0 SHALL be discarded; x0 SHALL read as 0.
REQ-014 Data memory SHALL be word-addressed by (rs1+imm)[9:2]; byte offset bits [1:0] are ignored.
REQ-015 Data memory reads SHALL be combinational; writes SHALL be synchronous at the rising edge for SW only.
REQ-016 Address wrap-around: pc and data addresses SHALL index modulo 256 words (bits [9:2]).
REQ-017 Any unsupported opcode/funct combination (e.g. 0xFFFFFFFF) SHALL behave as a NOP: no register or memory write, next_pc = pc+4.
REQ-018 Arithmetic SHALL be 32-bit two's complement with overflow silently wrapped.

Reset
REQ-019 While reset is high, pc SHALL be 0 and all 32 registers SHALL be 0.
REQ-020 Reset SHALL be asynchronous; reset asserted mid-program SHALL immediately force pc=0 with no register/memory write on that edge.
REQ-021 Instruction and data memories SHALL NOT be reset; contents persist across reset.

Configuration
REQ-022 Macro CORE_MUL_EN SHALL control MUL support.
- Defined: MUL (0110011, f3 000, f7 0000001) writes the low 32 bits of rs1*rs2 to rd.
- Undefined: that encoding is an illegal instruction per REQ-017.

Structure
REQ-023 Package core_pkg SHALL hold:
- Opcode constants, funct3/funct7 constants.
- ALU-op enum.
- XLEN=32, IMEM_WORDS=256, DMEM_WORDS=256.
REQ-024 The natural sub-module is core_regfile (instance regfile_inst).
REQ-025 Fetch, decode, ALU and data memory SHALL be implemented so that the hierarchical names in REQ-005 exist.

Verification
REQ-026 ADDI x1,x0,10; ADDI x2,x0,20; ADD x3,x1,x2 -> x1=10, x2=20, x3=30.
REQ-027 SUB x5,x2,x1 -> x5=10; with CORE_MUL_EN defined, MUL x7,x1,x2 -> x7=200; without it, x7 unchanged.
REQ-028 SW x3,0(x0); LW x9,0(x0); SW x4,4(x0) with x4=20 -> dmem[0]=30, x9=30, dmem[1]=20.
REQ-029 BEQ x1,x1,+12 skips two ADDIs and target ADDI x11,x0,111 -> x11=111; BEQ x1,x2,+8 not taken -> next ADDI executes.
REQ-030 JAL at pc=0x48 with rd=x13, offset 16 -> x13=0x4C, pc=0x58; JALR x14,4(x1) with x1=10 -> pc=14 & ~1 = 14 (0xE, fetch from word 3), x14 = pc+4.
REQ-031 LUI x15,0x12345 -> x15=0x12345000; then 0xFFFFFFFF executes as a NOP with pc+4 and no state change; reset asserted mid-run -> pc=0 and all registers 0 immediately.
